// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB memory completer.
//   APB_ADDR_W / APB_DATA_W : default paddr and data widths
//   apb_cmp_state_e         : completer FSM states (IDLE, WAIT, RESP)
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_cmp_state_e;

endpackage

// File: rtl/apb_mem_completer.sv
// apb_mem_completer: APB completer backed by a word-indexed flop memory, with
// wait states that can be changed per transfer and a PSLVERR response for
// out-of-range indices.
//   pclk, prst_n   clock / asynchronous active-low reset
//   paddr          word index (not a byte address)
//   pwdata, pwrite write data / direction (1 = write)
//   psel, pen      APB select / enable
//   i_wait         wait states for the next transfer, sampled at its setup edge
//   o_prdata       read data, valid with o_pready on a read, held otherwise
//   o_pready       completion handshake (registered)
//   o_pslverr      error response, only high together with o_pready
module apb_mem_completer
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DEPTH  = 32,
    parameter int WAIT_W = 4
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              pen,
    input  logic [WAIT_W-1:0] i_wait,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_cmp_state_e state, state_d;

    logic [WAIT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;

    logic              pready_d;
    logic              pslverr_d;
    logic [DATA_W-1:0] prdata_d;
    logic              setup;
    logic              commit;

    logic [DATA_W-1:0] mem [DEPTH];

    // Full-width unsigned compare: an index like 0x8000_0005 must error,
    // not alias onto word 5.
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    assign req_err = (paddr >= ADDR_W'(DEPTH));
    assign req_idx = paddr[IDX_W-1:0];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pready_d  = o_pready;
        pslverr_d = o_pslverr;
        prdata_d  = o_prdata;
        setup     = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                // pen is deliberately ignored here: any selected edge is a setup edge.
                if (psel) begin
                    setup = 1'b1;
                    cnt_d = i_wait;
                    if (i_wait == '0) begin
                        // Zero-wait: response uses the live bus, the latches load on this same edge.
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = req_err;
                        if (!pwrite) prdata_d = req_err ? '0 : mem[req_idx];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (pen) begin
                    // cnt is nonzero in WAIT; the guard keeps it from ever wrapping.
                    if (cnt != '0) cnt_d = cnt - 1'b1;
                    if (cnt == WAIT_W'(1)) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!write_q) prdata_d = err_q ? '0 : mem[idx_q];
                    end
                end
            end
            RESP: begin
                if (!psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (pen) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    commit    = write_q & ~err_q;
                end
            end
            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            o_pready  <= pready_d;
            o_pslverr <= pslverr_d;
            o_prdata  <= prdata_d;
            if (setup) begin
                idx_q   <= req_idx;
                wdata_q <= pwdata;
                write_q <= pwrite;
                err_q   <= req_err;
            end
        end
    end

    // Flop array so reset can clear every word; writes land only on completion.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
